// File: rtl/m_sr_pkg.sv
// Shared definitions for the set/reset latch bank: conflict modes, parameter
// bounds and the per-channel next-state rule.
package m_sr_pkg;

  typedef enum logic [1:0] {
    SR_SET_WINS   = 2'd0,
    SR_RESET_WINS = 2'd1,
    SR_HOLD       = 2'd2,
    SR_TOGGLE     = 2'd3
  } sr_mode_e;

  localparam int SR_FILTER_LEN_MAX = 15;
  localparam int SR_CHANNELS_MAX   = 32;

  // Next latch value from the two qualified requests; only a true conflict
  // consults the mode.
  function automatic logic sr_resolve(input logic     set_qual,
                                      input logic     rst_qual,
                                      input sr_mode_e mode,
                                      input logic     q);
    logic q_nxt;
    q_nxt = q;
    if (set_qual && !rst_qual) begin
      q_nxt = 1'b1;
    end else if (!set_qual && rst_qual) begin
      q_nxt = 1'b0;
    end else if (set_qual && rst_qual) begin
      case (mode)
        SR_SET_WINS:   q_nxt = 1'b1;
        SR_RESET_WINS: q_nxt = 1'b0;
        SR_HOLD:       q_nxt = q;
        SR_TOGGLE:     q_nxt = ~q;
        default:       q_nxt = q;
      endcase
    end
    return q_nxt;
  endfunction

endpackage

// File: rtl/m_sr_filter.sv
// Low-level qualifier for one active-low request: saturating run-length
// counter of consecutive low samples.
module m_sr_filter
  import m_sr_pkg::*;
#(
  parameter int FILTER_LEN = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_n,
  output logic qualify
);

  localparam int FLEN = (FILTER_LEN > SR_FILTER_LEN_MAX) ? SR_FILTER_LEN_MAX :
                        (FILTER_LEN < 1) ? 1 : FILTER_LEN;
  localparam int CW   = $clog2(FLEN + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(FLEN);
  localparam logic [CW-1:0] CNT_ARM = CW'(FLEN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (in_n) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Qualification lands on the edge the counter would reach FLEN, so the
  // latch updates on that same edge.
  generate
    if (FLEN == 1) begin : g_nofilt
      assign qualify = !in_n;
    end else begin : g_filt
      assign qualify = !in_n && (cnt >= CNT_ARM);
    end
  endgenerate

endmodule

// File: rtl/m_sr_latch_bank.sv
// Bank of clocked replacements for NAND set/reset latches, with input
// filtering, selectable conflict resolution, freeze and change pulses.
module m_sr_latch_bank
  import m_sr_pkg::*;
#(
  parameter int                  CHANNELS   = 4,
  parameter int                  FILTER_LEN = 1,
  parameter logic [CHANNELS-1:0] INIT_Q     = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] s_n,
  input  logic [CHANNELS-1:0] r_n,
  input  logic [1:0]          mode,
  input  logic                hold,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] ql,
  output logic [CHANNELS-1:0] changed
);

  logic [CHANNELS-1:0] set_qual;
  logic [CHANNELS-1:0] rst_qual;
  logic [CHANNELS-1:0] q_nxt;
  sr_mode_e            mode_e;

  assign mode_e = sr_mode_e'(mode);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      m_sr_filter #(.FILTER_LEN(FILTER_LEN)) u_set_filt (
        .clock   (clock),
        .reset   (reset),
        .in_n    (s_n[i]),
        .qualify (set_qual[i])
      );

      m_sr_filter #(.FILTER_LEN(FILTER_LEN)) u_rst_filt (
        .clock   (clock),
        .reset   (reset),
        .in_n    (r_n[i]),
        .qualify (rst_qual[i])
      );
    end
  endgenerate

  always_comb begin
    q_nxt = q;
    for (int i = 0; i < CHANNELS; i++) begin
      q_nxt[i] = sr_resolve(set_qual[i], rst_qual[i], mode_e, q[i]);
    end
  end

  // Filters keep counting through hold; only the latch state is frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= INIT_Q;
      ql      <= ~INIT_Q;
      changed <= '0;
    end else if (hold) begin
      changed <= '0;
    end else begin
      q       <= q_nxt;
      ql      <= ~q_nxt;
      changed <= q_nxt ^ q;
    end
  end

endmodule

// File: tb/tb_m_sr_latch_bank.sv
// Bench for m_sr_latch_bank: two instances (FILTER_LEN 3 and 1) driven with
// the same vectors, checked every cycle against a run-length model.
module tb_m_sr_latch_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s_n, r_n;
  logic [1:0] mode;
  logic       hold;
  logic [3:0] q3, ql3, ch3;
  logic [3:0] q1, ql1, ch1;

  always #5 clk = ~clk;

  m_sr_latch_bank #(.CHANNELS(4), .FILTER_LEN(3), .INIT_Q(4'b1010)) dut3 (
    .clock(clk), .reset(reset), .s_n(s_n), .r_n(r_n), .mode(mode), .hold(hold),
    .q(q3), .ql(ql3), .changed(ch3)
  );

  m_sr_latch_bank #(.CHANNELS(4), .FILTER_LEN(1), .INIT_Q(4'b0000)) dut1 (
    .clock(clk), .reset(reset), .s_n(s_n), .r_n(r_n), .mode(mode), .hold(hold),
    .q(q1), .ql(ql1), .changed(ch1)
  );

  // Model: per input, length of the current low run; qualified once the run
  // including this sample reaches FILTER_LEN.
  int         flv [2]   = '{3, 1};
  logic [3:0] initv [2] = '{4'b1010, 4'b0000};
  int         run_s [2][4];
  int         run_r [2][4];
  logic [3:0] mq [2];
  logic [3:0] mch [2];

  always @(posedge clk) begin
    logic qs, qr, nq;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (reset) begin
          run_s[d][i] = 0;
          run_r[d][i] = 0;
          mq[d][i]    = initv[d][i];
          mch[d][i]   = 1'b0;
        end else begin
          qs = !s_n[i] && (run_s[d][i] + 1 >= flv[d]);
          qr = !r_n[i] && (run_r[d][i] + 1 >= flv[d]);
          run_s[d][i] = s_n[i] ? 0 : ((run_s[d][i] < 100) ? run_s[d][i] + 1 : run_s[d][i]);
          run_r[d][i] = r_n[i] ? 0 : ((run_r[d][i] < 100) ? run_r[d][i] + 1 : run_r[d][i]);
          if (hold) begin
            mch[d][i] = 1'b0;
          end else begin
            nq = mq[d][i];
            if (qs && !qr) nq = 1'b1;
            else if (qr && !qs) nq = 1'b0;
            else if (qs && qr) begin
              case (mode)
                2'd0: nq = 1'b1;
                2'd1: nq = 1'b0;
                2'd2: nq = mq[d][i];
                default: nq = ~mq[d][i];
              endcase
            end
            mch[d][i] = (nq != mq[d][i]);
            mq[d][i]  = nq;
          end
        end
      end
    end
  end

  // Hand-computed expectations posted by the stimulus for the next edge.
  logic       e3_en = 1'b0, e1_en = 1'b0;
  logic [3:0] e3_qm, e3_qv, e3_cm, e3_cv;
  logic [3:0] e1_qm, e1_qv, e1_cm, e1_cv;
  string      e3_nm, e1_nm;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("q_fl3",   q3,  mq[0]);
    chk("ql_fl3",  ql3, ~mq[0]);
    chk("chg_fl3", ch3, mch[0]);
    chk("q_fl1",   q1,  mq[1]);
    chk("ql_fl1",  ql1, ~mq[1]);
    chk("chg_fl1", ch1, mch[1]);
    if (e3_en) begin
      if (e3_qm != 4'b0000) begin
        chk({e3_nm, "_q_fl3"},  q3 & e3_qm,  e3_qv & e3_qm);
        chk({e3_nm, "_ql_fl3"}, ql3 & e3_qm, ~e3_qv & e3_qm);
      end
      if (e3_cm != 4'b0000) chk({e3_nm, "_chg_fl3"}, ch3 & e3_cm, e3_cv & e3_cm);
    end
    if (e1_en) begin
      if (e1_qm != 4'b0000) begin
        chk({e1_nm, "_q_fl1"},  q1 & e1_qm,  e1_qv & e1_qm);
        chk({e1_nm, "_ql_fl1"}, ql1 & e1_qm, ~e1_qv & e1_qm);
      end
      if (e1_cm != 4'b0000) chk({e1_nm, "_chg_fl1"}, ch1 & e1_cm, e1_cv & e1_cm);
    end
  end

  task automatic expect3(input string nm, input logic [3:0] qm, input logic [3:0] qv,
                         input logic [3:0] cm, input logic [3:0] cv);
    e3_en = 1'b1; e3_nm = nm; e3_qm = qm; e3_qv = qv; e3_cm = cm; e3_cv = cv;
  endtask

  task automatic expect1(input string nm, input logic [3:0] qm, input logic [3:0] qv,
                         input logic [3:0] cm, input logic [3:0] cv);
    e1_en = 1'b1; e1_nm = nm; e1_qm = qm; e1_qv = qv; e1_cm = cm; e1_cv = cv;
  endtask

  // Advance one edge; inputs change 1 time unit after the checking edge.
  task automatic tick();
    @(negedge clk);
    #1;
    e3_en = 1'b0;
    e1_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_n = 4'hF; r_n = 4'hF; mode = 2'd0; hold = 1'b0;
    expect3("rst", 4'hF, 4'b1010, 4'hF, 4'h0);
    expect1("rst", 4'hF, 4'b0000, 4'hF, 4'h0);
    tick();
    tick();
    reset = 1'b0;

    // filtered set on ch0
    s_n = 4'b1110;
    expect3("fset1", 4'hF, 4'b1010, 4'hF, 4'h0);
    expect1("fset1", 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    tick();
    expect3("fset2", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    tick();
    expect3("fset3", 4'hF, 4'b1011, 4'hF, 4'b0001);
    tick();
    expect3("fset4", 4'hF, 4'b1011, 4'hF, 4'b0000);
    tick();
    s_n = 4'hF; r_n = 4'b1110;
    tick();
    tick();
    expect3("frst", 4'hF, 4'b1010, 4'hF, 4'b0001);
    tick();
    r_n = 4'hF;
    tick();
    s_n = 4'b1110;
    expect3("pulse1", 4'hF, 4'b1010, 4'hF, 4'b0000);
    tick();
    expect3("pulse2", 4'hF, 4'b1010, 4'hF, 4'b0000);
    tick();
    s_n = 4'hF;
    expect3("pulse3", 4'hF, 4'b1010, 4'hF, 4'b0000);
    tick();
    tick();

    // conflict modes on ch1
    s_n = 4'b1101; r_n = 4'b1101;
    mode = 2'd0; expect1("m0", 4'b0010, 4'b0010, 4'b0010, 4'b0010); tick();
    mode = 2'd1; expect1("m1", 4'b0010, 4'b0000, 4'b0010, 4'b0010); tick();
    mode = 2'd2; expect1("m2", 4'b0010, 4'b0000, 4'b0010, 4'b0000); tick();
    mode = 2'd3; expect1("m3a", 4'b0010, 4'b0010, 4'b0010, 4'b0010); tick();
    expect1("m3b", 4'b0010, 4'b0000, 4'b0010, 4'b0010); tick();
    expect1("m3c", 4'b0010, 4'b0010, 4'b0010, 4'b0010); tick();
    expect1("m3d", 4'b0010, 4'b0000, 4'b0010, 4'b0010); tick();
    s_n = 4'hF; r_n = 4'hF; mode = 2'd0;
    expect1("mrel", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    tick();

    // freeze while ch2 set qualifies
    hold = 1'b1; s_n = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      expect1("frz", 4'b0100, 4'b0000, 4'hF, 4'h0);
      expect3("frz", 4'b0100, 4'b0000, 4'hF, 4'h0);
      tick();
    end
    hold = 1'b0;
    expect1("unfrz", 4'b0100, 4'b0100, 4'b0100, 4'b0100);
    expect3("unfrz", 4'b0100, 4'b0100, 4'b0100, 4'b0100);
    tick();
    s_n = 4'hF;
    tick();

    // reset after 2 of 3 filter clocks
    s_n = 4'b1110;
    expect3("pre1", 4'b0001, 4'b0000, 4'b0000, 4'b0000); tick();
    expect3("pre2", 4'b0001, 4'b0000, 4'b0000, 4'b0000); tick();
    reset = 1'b1;
    expect3("midrst", 4'hF, 4'b1010, 4'hF, 4'h0);
    expect1("midrst", 4'hF, 4'b0000, 4'hF, 4'h0);
    tick();
    reset = 1'b0;
    expect3("post1", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    expect1("post1", 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    tick();
    expect3("post2", 4'b0001, 4'b0000, 4'b0001, 4'b0000); tick();
    expect3("post3", 4'hF, 4'b1011, 4'hF, 4'b0001); tick();
    s_n = 4'hF;
    tick();

    // ch0/ch3 activity must not disturb ch1/ch2
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) s_n[0] = ~s_n[0];
      if ($urandom_range(0, 3) == 0) s_n[3] = ~s_n[3];
      if ($urandom_range(0, 3) == 0) r_n[0] = ~r_n[0];
      if ($urandom_range(0, 3) == 0) r_n[3] = ~r_n[3];
      if (k % 64 == 0) mode = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 15) == 0);
      expect3("indep", 4'b0110, 4'b0010, 4'b0110, 4'b0000);
      expect1("indep", 4'b0110, 4'b0000, 4'b0110, 4'b0000);
      tick();
    end

    s_n = 4'hF; r_n = 4'hF; hold = 1'b0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_sr_latch_bank.md
M_SR_LATCH_BANK -- requirements
Module: m_sr_latch_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent set/reset channels, range 1..32.
REQ-002 Parameter FILTER_LEN, default 1: consecutive sampled-low clocks needed to qualify an input, range 1..15; 1 means no filtering.
REQ-003 Parameter INIT_Q, default all zeros, width CHANNELS: per-channel q value after reset.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_n  in  CHANNELS  per-channel set request, active-low, as on the NAND latch it replaces.
REQ-008 r_n  in  CHANNELS  per-channel reset request, active-low.
REQ-009 mode  in  2  conflict mode for all channels: 0 set-wins, 1 reset-wins, 2 hold, 3 toggle.
REQ-010 hold  in  1  freeze; when high, q/ql do not change.
REQ-011 q  out  CHANNELS  registered latch state.
REQ-012 ql  out  CHANNELS  registered complement; always equals ~q.
REQ-013 changed  out  CHANNELS  one-cycle pulse, registered, high on the cycle after q[i] changed.

Function
REQ-014 Each of s_n[i] and r_n[i] SHALL have a saturating counter: increment while the input samples low, clear to 0 when it samples high, saturate at FILTER_LEN.
REQ-015 Input qualification: an input SHALL be qualified on the edge where its counter reaches or holds at FILTER_LEN, with the current sample low.
REQ-016 With FILTER_LEN=1, an input SHALL be qualified on the first edge at which it samples low.
REQ-017 Latency: q SHALL update on the same edge that qualification occurs (FILTER_LEN edges after the input first samples low).
REQ-018 Set qualified only: q SHALL be set to 1.
REQ-019 Reset qualified only: q SHALL be set to 0.
REQ-020 Neither qualified: q SHALL hold its value.
REQ-021 Both qualified, outcome by mode: mode 0 gives q=1; mode 1 gives q=0; mode 2 holds q; mode 3 inverts q on every edge while both stay qualified.
REQ-022 Mode changes SHALL take effect on the next edge and SHALL NOT clear the counters.
REQ-023 hold=1: q, ql and changed SHALL freeze at their current values (changed forced 0), while counters keep running.
REQ-024 hold release: q SHALL be evaluated on the first edge with hold=0 using the then-current qualification.
REQ-025 changed[i] SHALL be 1 for exactly one cycle following each edge where q[i] changed value; during mode-3 toggling it SHALL stay high every cycle.
REQ-026 Channels SHALL be fully independent; there SHALL be no cross-channel priority.

Reset
REQ-027 On reset=1 at an edge: q=INIT_Q, ql=~INIT_Q, changed=0, all counters=0; reset dominates s_n, r_n, hold and mode.
REQ-028 Reset mid-filter: partial counts SHALL be discarded, and an input held low across reset SHALL need a full FILTER_LEN clocks after reset deasserts to qualify.
REQ-029 changed SHALL NOT pulse on the first edge after reset, even when INIT_Q differs from the previous q.

Structure
REQ-030 A shared package m_sr_pkg SHALL hold the conflict-mode enum (SR_SET_WINS, SR_RESET_WINS, SR_HOLD, SR_TOGGLE) and the FILTER_LEN bound constant.
REQ-031 A sub-module m_sr_filter SHALL hold one input counter and its qualify output; it SHALL be instantiated 2*CHANNELS times through generate.
REQ-032 Counter width SHALL be $clog2(FILTER_LEN+1); there SHALL be no combinational path from s_n or r_n to q, ql or changed.

Verification
REQ-033 Filtered set: FILTER_LEN=3, reset, then s_n[0] low for 3 clocks -> q[0] rises on the 3rd edge, changed[0] high for one cycle after it; a 2-clock low pulse -> no change.
REQ-034 Conflict modes: both s_n[1] and r_n[1] low, FILTER_LEN=1, q[1]=0 -> mode 0 gives q=1; mode 1 gives q=0; mode 2 keeps 0; mode 3 gives 1,0,1,0 on successive edges with changed high throughout.
REQ-035 Freeze: hold=1 while s_n[2] qualifies -> q[2] stays 0 and changed stays 0; drop hold -> q[2]=1 on the next edge.
REQ-036 Reset mid-operation: INIT_Q=4'b1010, reset asserted after 2 of 3 filter clocks -> q=1010, ql=0101, changed=0000; s_n held low then needs 3 further clocks.
REQ-037 Channel independence: CHANNELS=4, random s_n/r_n on ch0 and ch3 for 1000 cycles against a reference model -> ch1 and ch2 unchanged, ql==~q every cycle.
